warp_reg_file: RTL and testbench
================================

Name: warp_reg_file

Overview:
- Per-lane register file for a SIMD core: NUM_THREADS lanes, each with NUM_REGS registers of DATA_W bits.
- Two registered read ports, one masked write port, and top-3 special registers per lane loaded on a launch pulse.
- Per-register pending scoreboard so decode stalls on reads of registers awaiting long-latency (LSU) writeback.
- Sits between decode/issue and ALU/LSU in each core; successor to the single-lane 16x16 file.

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 16, registers per lane (minimum 4); top 3 are special.
- NUM_THREADS, 4, lanes per warp.
- ADDR_W, $clog2(NUM_REGS), register address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- launch  in  1  one-cycle pulse; loads special regs and clears scoreboard
- block_idx  in  DATA_W  value for reg NUM_REGS-3, all lanes
- block_dim  in  DATA_W  value for reg NUM_REGS-2, all lanes
- thread_base  in  DATA_W  lane L gets thread_base+L in reg NUM_REGS-1
- rd_en  in  1  read request
- A1  in  ADDR_W  source 1 address
- A2  in  ADDR_W  source 2 address
- RS1  out  NUM_THREADS*DATA_W  source 1 data, lane L at [L*DATA_W +: DATA_W]
- RS2  out  NUM_THREADS*DATA_W  source 2 data, same packing
- rd_valid  out  1  RS1/RS2 updated this cycle
- hazard  out  1  combinational: rd_en && (pend[A1] || pend[A2])
- we  in  1  write enable
- A3  in  ADDR_W  write address
- wmask  in  NUM_THREADS  per-lane write enable
- WD  in  NUM_THREADS*DATA_W  write data, same packing
- pend_set  in  1  mark register pend_addr pending (LSU load issued)
- pend_addr  in  ADDR_W  register to mark pending
- pending  out  NUM_REGS  scoreboard bits

Behaviour:
- Reset (reset=0, async):
  - All registers, including specials, = 0.
  - RS1 = RS2 = 0; rd_valid = 0; pending = 0.
- Read:
  - Registered, 1-cycle latency.
  - If rd_en && !hazard at edge N: RS1/RS2 hold array[A1]/[A2] for all lanes after edge N, and rd_valid=1 for that one cycle.
  - If !rd_en or hazard: RS1/RS2 hold their previous values; rd_valid=0.
  - A read returns pre-edge contents: a same-cycle write is not visible unless WRITE_BYPASS_EN.
- Write:
  - At edge, if we && A3 < NUM_REGS-3: lane L register A3 <= WD lane L for each L with wmask[L]=1. Unmasked lanes are unchanged.
  - Writes to special addresses are silently dropped.
- Scoreboard:
  - pend_set sets pending[pend_addr] at edge.
  - Any we to A3 clears pending[A3], regardless of wmask.
  - pend_set and we to the same address in the same cycle: set wins (the newer op).
  - pend_set to a special address is ignored.
- Launch (priority over we and pend_set in the same cycle; both are dropped):
  - Lane L: reg NUM_REGS-3 <= block_idx; NUM_REGS-2 <= block_dim; NUM_REGS-1 <= (thread_base+L) mod 2^DATA_W.
  - pending <= 0.
  - General registers are retained.
  - A read in the launch cycle is still serviced and returns pre-launch values.
- Reset asserted mid-operation: immediate clear as above; in-flight reads are lost.
- Address arithmetic: A1/A2/A3 >= NUM_REGS (non-power-of-2 NUM_REGS) reads 0, writes dropped.

Optional Feature:
- Macro: WARP_REG_FILE_WRITE_BYPASS_EN.
- Defined: on a read, a same-cycle write with A3==A1 (or A2) supplies WD for lanes with wmask set. Lanes with wmask clear read the array. A same-cycle write to a pending source also suppresses hazard for that source, because the write clears it.
- Undefined: no forwarding; reads see pre-edge array contents and hazard uses only the registered pending bits.

Test Plan:
All cases use DATA_W=16, NUM_REGS=16, NUM_THREADS=4.
- Reset released, then rd_en with A1=0, A2=15 -> next cycle rd_valid=1, RS1=RS2=0 in all lanes.
- launch with block_idx=0x0002, block_dim=0x0020, thread_base=0xFFFE; then read A1=13, A2=15 -> RS1 all lanes 0x0002; RS2 lanes 0..3 = 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- we, A3=5, wmask=4'b0101, WD lanes=0x1111/0x2222/0x3333/0x4444 over prior zeros; read A1=5 -> 0x1111, 0x0000, 0x3333, 0x0000. Write to A3=14 -> reg 14 unchanged.
- pend_set pend_addr=7; next cycle rd_en A2=7 -> hazard=1, rd_valid=0, RS held. Then we A3=7 WD=0xBEEF, wmask=0 -> pending[7]=0; read A2=7 -> rd_valid=1.
- Same cycle: pend_set addr 3 with we A3=3 -> pending[3]=1 after edge. launch with we A3=2 -> reg 2 unchanged, pending=0.
- With bypass defined: we A3=4 WD=0xAAAA wmask=4'hF and rd_en A1=4 in the same cycle -> RS1=0xAAAA all lanes next cycle. Without bypass -> RS1 = prior value.

Source files
------------

// File: rtl/warp_reg_file_if.sv
// warp_reg_file_if: issue-side bundle of the per-lane SIMD register file.
//   launch/block_idx/block_dim/thread_base : warp launch and special register values
//   rd_en/A1/A2 -> RS1/RS2/rd_valid/hazard : dual registered read port with stall
//   we/A3/wmask/WD                         : lane-masked write port
//   pend_set/pend_addr -> pending          : long-latency writeback scoreboard
// Lane L of every packed data bus sits at [L*DATA_W +: DATA_W].
// master = decode/issue side, slave = register file.
interface warp_reg_file_if #(
    parameter int DATA_W      = 16,
    parameter int NUM_REGS    = 16,
    parameter int NUM_THREADS = 4,
    parameter int ADDR_W      = $clog2(NUM_REGS)
);
    logic                          launch;
    logic [DATA_W-1:0]             block_idx;
    logic [DATA_W-1:0]             block_dim;
    logic [DATA_W-1:0]             thread_base;
    logic                          rd_en;
    logic [ADDR_W-1:0]             A1;
    logic [ADDR_W-1:0]             A2;
    logic [NUM_THREADS*DATA_W-1:0] RS1;
    logic [NUM_THREADS*DATA_W-1:0] RS2;
    logic                          rd_valid;
    logic                          hazard;
    logic                          we;
    logic [ADDR_W-1:0]             A3;
    logic [NUM_THREADS-1:0]        wmask;
    logic [NUM_THREADS*DATA_W-1:0] WD;
    logic                          pend_set;
    logic [ADDR_W-1:0]             pend_addr;
    logic [NUM_REGS-1:0]           pending;

    modport master (
        output launch, block_idx, block_dim, thread_base,
        output rd_en, A1, A2,
        input  RS1, RS2, rd_valid, hazard,
        output we, A3, wmask, WD,
        output pend_set, pend_addr,
        input  pending
    );

    modport slave (
        input  launch, block_idx, block_dim, thread_base,
        input  rd_en, A1, A2,
        output RS1, RS2, rd_valid, hazard,
        input  we, A3, wmask, WD,
        input  pend_set, pend_addr,
        output pending
    );
endinterface

// File: rtl/warp_reg_file.sv
// warp_reg_file: per-lane register file for a SIMD core.
//   NUM_THREADS lanes x NUM_REGS registers x DATA_W bits. The top three
//   registers of each lane are special (block_idx, block_dim, thread id)
//   and are loaded only by launch; ordinary writes to them are dropped.
// Ports:
//   clk   : clock
//   reset : asynchronous active-low reset, clears everything
//   bus   : warp_reg_file_if.slave (launch, read, write, scoreboard)
// Reads are registered (1-cycle latency); hazard is combinational and
// stalls a read whose source is waiting on an LSU writeback.
// Optional build macro WARP_REG_FILE_WRITE_BYPASS_EN forwards a same-cycle
// write into the read result and lets that write cancel the source hazard.
module warp_reg_file #(
    parameter int DATA_W      = 16,
    parameter int NUM_REGS    = 16,
    parameter int NUM_THREADS = 4,
    parameter int ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic           clk,
    input  logic           reset,
    warp_reg_file_if.slave bus
);
    localparam int              LANE_BITS    = NUM_THREADS * DATA_W;
    localparam logic [ADDR_W:0] SPECIAL_BASE = (ADDR_W+1)'(NUM_REGS - 3);
    localparam logic [ADDR_W:0] REG_LIMIT    = (ADDR_W+1)'(NUM_REGS);

    // Address exists in the file (matters only for non-power-of-2 NUM_REGS).
    function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < REG_LIMIT);
    endfunction

    // Address is a general (writable, trackable) register.
    function automatic logic addr_general(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < SPECIAL_BASE);
    endfunction

    // One-hot scoreboard mask for an address.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] a);
        return NUM_REGS'(1) << a;
    endfunction

    logic [DATA_W-1:0]      regs_r [NUM_THREADS][NUM_REGS];
    logic [NUM_REGS-1:0]    pend_r;
    logic [LANE_BITS-1:0]   rs1_r;
    logic [LANE_BITS-1:0]   rs2_r;
    logic                   rd_valid_r;

    logic                   write_fire_s;
    logic                   clear_fire_s;
    logic                   set_fire_s;
    logic                   sup1_s;
    logic                   sup2_s;
    logic [NUM_THREADS-1:0] fwd1_s;
    logic [NUM_THREADS-1:0] fwd2_s;
    logic                   src1_pend_s;
    logic                   src2_pend_s;
    logic                   hazard_s;
    logic                   read_fire_s;
    logic [LANE_BITS-1:0]   rd1_s;
    logic [LANE_BITS-1:0]   rd2_s;
    logic [NUM_REGS-1:0]    clear_vec_s;
    logic [NUM_REGS-1:0]    set_vec_s;
    logic [NUM_REGS-1:0]    pend_next_s;

    // Launch owns the cycle: any write or pend_set alongside it is dropped.
    assign write_fire_s = bus.we && !bus.launch && addr_general(bus.A3);
    assign clear_fire_s = bus.we && !bus.launch && addr_valid(bus.A3);
    assign set_fire_s   = bus.pend_set && !bus.launch && addr_general(bus.pend_addr);

`ifdef WARP_REG_FILE_WRITE_BYPASS_EN
    // Forwarding selects: a same-cycle write both supplies data and clears the pending bit.
    always_comb begin
        sup1_s = write_fire_s && (bus.A3 == bus.A1);
        sup2_s = write_fire_s && (bus.A3 == bus.A2);
        fwd1_s = sup1_s ? bus.wmask : {NUM_THREADS{1'b0}};
        fwd2_s = sup2_s ? bus.wmask : {NUM_THREADS{1'b0}};
    end
`else
    // No forwarding: reads see only the pre-edge array and registered pending bits.
    always_comb begin
        sup1_s = 1'b0;
        sup2_s = 1'b0;
        fwd1_s = {NUM_THREADS{1'b0}};
        fwd2_s = {NUM_THREADS{1'b0}};
    end
`endif

    // Source hazard detection from the scoreboard.
    always_comb begin
        src1_pend_s = (addr_valid(bus.A1) ? pend_r[bus.A1] : 1'b0) && !sup1_s;
        src2_pend_s = (addr_valid(bus.A2) ? pend_r[bus.A2] : 1'b0) && !sup2_s;
        hazard_s    = bus.rd_en && (src1_pend_s || src2_pend_s);
        read_fire_s = bus.rd_en && !hazard_s;
    end

    // Per-lane read data: forwarded write, array contents, or zero when out of range.
    always_comb begin
        rd1_s = {LANE_BITS{1'b0}};
        rd2_s = {LANE_BITS{1'b0}};
        for (int l = 0; l < NUM_THREADS; l++) begin
            if (fwd1_s[l]) begin
                rd1_s[l*DATA_W +: DATA_W] = bus.WD[l*DATA_W +: DATA_W];
            end else if (addr_valid(bus.A1)) begin
                rd1_s[l*DATA_W +: DATA_W] = regs_r[l][bus.A1];
            end else begin
                rd1_s[l*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end
            if (fwd2_s[l]) begin
                rd2_s[l*DATA_W +: DATA_W] = bus.WD[l*DATA_W +: DATA_W];
            end else if (addr_valid(bus.A2)) begin
                rd2_s[l*DATA_W +: DATA_W] = regs_r[l][bus.A2];
            end else begin
                rd2_s[l*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end
        end
    end

    // Scoreboard next state: clear by write first, then set so the newer pend_set wins.
    always_comb begin
        clear_vec_s = clear_fire_s ? onehot(bus.A3) : {NUM_REGS{1'b0}};
        set_vec_s   = set_fire_s ? onehot(bus.pend_addr) : {NUM_REGS{1'b0}};
        pend_next_s = bus.launch ? {NUM_REGS{1'b0}} : ((pend_r & ~clear_vec_s) | set_vec_s);
    end

    // Register array: launch loads the specials of every lane, writes are lane-masked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int l = 0; l < NUM_THREADS; l++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    regs_r[l][r] <= {DATA_W{1'b0}};
                end
            end
        end else if (bus.launch) begin
            for (int l = 0; l < NUM_THREADS; l++) begin
                regs_r[l][NUM_REGS-3] <= bus.block_idx;
                regs_r[l][NUM_REGS-2] <= bus.block_dim;
                regs_r[l][NUM_REGS-1] <= bus.thread_base + DATA_W'(l);
            end
        end else if (write_fire_s) begin
            for (int l = 0; l < NUM_THREADS; l++) begin
                if (bus.wmask[l]) begin
                    regs_r[l][bus.A3] <= bus.WD[l*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Read result registers: hold last data when the read stalls or is idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs1_r      <= {LANE_BITS{1'b0}};
            rs2_r      <= {LANE_BITS{1'b0}};
            rd_valid_r <= 1'b0;
        end else if (read_fire_s) begin
            rs1_r      <= rd1_s;
            rs2_r      <= rd2_s;
            rd_valid_r <= 1'b1;
        end else begin
            rd_valid_r <= 1'b0;
        end
    end

    // Pending scoreboard register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_r <= {NUM_REGS{1'b0}};
        end else begin
            pend_r <= pend_next_s;
        end
    end

    assign bus.RS1      = rs1_r;
    assign bus.RS2      = rs2_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.hazard   = hazard_s;
    assign bus.pending  = pend_r;
endmodule

// File: tb/tb_warp_reg_file.sv
// tb_warp_reg_file: scoreboard bench for warp_reg_file (16-bit, 16 regs, 4 lanes).
// Stimulus pushes the expected {RS1,RS2} of each serviced read into a queue;
// a negedge monitor pops and compares whenever rd_valid is seen.
// Honours WARP_REG_FILE_WRITE_BYPASS_EN for the forwarding cases.
module tb_warp_reg_file;
    localparam int DW = 16;
    localparam int NR = 16;
    localparam int NT = 4;
    localparam int AW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    warp_reg_file_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_THREADS(NT), .ADDR_W(AW)) bus ();

    warp_reg_file #(.DATA_W(DW), .NUM_REGS(NR), .NUM_THREADS(NT), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int           tests = 0;
    int           fails = 0;
    logic [127:0] exp_q [$];
    string        name_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [15:0] l3, input logic [15:0] l2,
                                         input logic [15:0] l1, input logic [15:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [63:0] all4(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    // Monitor: every rd_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [127:0] e;
        string        n;
        if (reset && bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rd_valid", {63'd0, bus.rd_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check({n, "_rs1"}, bus.RS1, e[127:64]);
                check({n, "_rs2"}, bus.RS2, e[63:0]);
            end
        end
    end

    task automatic idle();
        bus.launch   = 1'b0;
        bus.rd_en    = 1'b0;
        bus.we       = 1'b0;
        bus.pend_set = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic expect_read(input string n, input logic [63:0] e1, input logic [63:0] e2);
        exp_q.push_back({e1, e2});
        name_q.push_back(n);
    endtask

    task automatic set_read(input logic [3:0] a1, input logic [3:0] a2);
        bus.rd_en = 1'b1;
        bus.A1    = a1;
        bus.A2    = a2;
    endtask

    task automatic set_write(input logic [3:0] a3, input logic [3:0] m, input logic [63:0] d);
        bus.we    = 1'b1;
        bus.A3    = a3;
        bus.wmask = m;
        bus.WD    = d;
    endtask

    task automatic set_pend(input logic [3:0] a);
        bus.pend_set  = 1'b1;
        bus.pend_addr = a;
    endtask

    task automatic do_read(input string n, input logic [3:0] a1, input logic [3:0] a2,
                           input logic [63:0] e1, input logic [63:0] e2);
        set_read(a1, a2);
        expect_read(n, e1, e2);
        step();
    endtask

    initial begin
        idle();
        bus.block_idx = 16'h0000; bus.block_dim = 16'h0000; bus.thread_base = 16'h0000;
        bus.A1 = 4'd0; bus.A2 = 4'd0; bus.A3 = 4'd0; bus.pend_addr = 4'd0;
        bus.wmask = 4'h0; bus.WD = 64'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_rs1", bus.RS1, 64'd0);
        check("reset_rs2", bus.RS2, 64'd0);
        check("reset_rd_valid", {63'd0, bus.rd_valid}, 64'd0);
        check("reset_pending", {48'd0, bus.pending}, 64'd0);
        reset = 1'b1;
        step();

        do_read("rd_after_reset", 4'd0, 4'd15, 64'd0, 64'd0);

        // Launch loads specials; thread id wraps across lanes
        bus.launch = 1'b1;
        bus.block_idx = 16'h0002; bus.block_dim = 16'h0020; bus.thread_base = 16'hFFFE;
        step();
        do_read("rd_specials", 4'd13, 4'd15, all4(16'h0002),
                pack(16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE));

        // Masked write, then a dropped write to a special register
        set_write(4'd5, 4'b0101, pack(16'h4444, 16'h3333, 16'h2222, 16'h1111));
        step();
        do_read("rd_masked", 4'd5, 4'd14, pack(16'h0000, 16'h3333, 16'h0000, 16'h1111),
                all4(16'h0020));
        set_write(4'd14, 4'hF, all4(16'h5555));
        step();
        do_read("rd_special_kept", 4'd14, 4'd13, all4(16'h0020), all4(16'h0002));

        // Pending source stalls the read and holds RS
        set_pend(4'd7);
        step();
        check("pend7_set", {48'd0, bus.pending}, 64'h0080);
        set_read(4'd0, 4'd7);
        #1;
        check("hazard_pend7", {63'd0, bus.hazard}, 64'd1);
        step();
        check("stall_no_valid", {63'd0, bus.rd_valid}, 64'd0);
        check("stall_rs1_held", bus.RS1, all4(16'h0020));
        check("stall_rs2_held", bus.RS2, all4(16'h0002));
        set_write(4'd7, 4'h0, all4(16'hBEEF));
        step();
        check("pend7_cleared_mask0", {48'd0, bus.pending}, 64'd0);
        do_read("rd_after_clear", 4'd5, 4'd7, pack(16'h0000, 16'h3333, 16'h0000, 16'h1111),
                64'd0);
        set_pend(4'd14);
        step();
        check("pend_special_ignored", {48'd0, bus.pending}, 64'd0);

        // Same-cycle pend_set and write: set wins
        set_pend(4'd3);
        set_write(4'd3, 4'hF, all4(16'h7777));
        step();
        check("pend_set_wins", {48'd0, bus.pending}, 64'h0008);

        // Launch drops write and pend_set, clears scoreboard, serves read with old values
        bus.launch = 1'b1;
        bus.block_idx = 16'h0003; bus.block_dim = 16'h0030; bus.thread_base = 16'h0010;
        set_write(4'd2, 4'hF, all4(16'h9999));
        set_pend(4'd9);
        set_read(4'd13, 4'd15);
        expect_read("rd_in_launch", all4(16'h0002), pack(16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE));
        step();
        check("launch_clears_pending", {48'd0, bus.pending}, 64'd0);
        do_read("rd_launch_dropped_wr", 4'd2, 4'd15, 64'd0,
                pack(16'h0013, 16'h0012, 16'h0011, 16'h0010));
        do_read("rd_gen_retained", 4'd3, 4'd14, all4(16'h7777), all4(16'h0030));

        // Same-cycle write and read of one register
        set_write(4'd4, 4'hF, all4(16'hAAAA));
        set_read(4'd4, 4'd13);
`ifdef WARP_REG_FILE_WRITE_BYPASS_EN
        expect_read("rd_same_cycle_wr", all4(16'hAAAA), all4(16'h0003));
`else
        expect_read("rd_same_cycle_wr", 64'd0, all4(16'h0003));
`endif
        step();

        // Write to a pending source in the read cycle
        set_pend(4'd6);
        step();
        set_write(4'd6, 4'hF, all4(16'hBBBB));
        set_read(4'd6, 4'd4);
        #1;
`ifdef WARP_REG_FILE_WRITE_BYPASS_EN
        check("hazard_bypassed", {63'd0, bus.hazard}, 64'd0);
        expect_read("rd_bypass_pending", all4(16'hBBBB), all4(16'hAAAA));
`else
        check("hazard_no_bypass", {63'd0, bus.hazard}, 64'd1);
`endif
        step();
        check("pend6_cleared", {48'd0, bus.pending}, 64'd0);
        do_read("rd_after_writes", 4'd6, 4'd4, all4(16'hBBBB), all4(16'hAAAA));

        // Reset mid-operation drops the in-flight read and clears state
        set_pend(4'd8);
        step();
        check("pend8_set", {48'd0, bus.pending}, 64'h0100);
        set_read(4'd4, 4'd6);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_pending", {48'd0, bus.pending}, 64'd0);
        check("midreset_rs1", bus.RS1, 64'd0);
        check("midreset_rd_valid", {63'd0, bus.rd_valid}, 64'd0);
        idle();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        do_read("rd_after_midreset", 4'd4, 4'd15, 64'd0, 64'd0);

        repeat (3) step();
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
